// File: rtl/control_unit.sv
// control_unit: multicycle sequencer for the KGP-RISC datapath.
// Steps each instruction through IF/ID/EX/MEM/WB, drives every datapath
// load/select/enable, counts retired instructions and flags undefined opcodes.
module control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             run,
    input  logic [31:0]      irout,
    output logic             readim,
    output logic             ldir,
    output logic             ldnpc,
    output logic             ldA,
    output logic             ldB,
    output logic             ldimm,
    output logic [1:0]       opcond,
    output logic             alusel1,
    output logic             alusel2,
    output logic             aluen,
    output logic             ldaluout,
    output logic [3:0]       alufunc,
    output logic             seldest,
    output logic             regwrite,
    output logic             writedmem,
    output logic             readdmem,
    output logic             ldlmd,
    output logic             selwb,
    output logic             branch,
    output logic             ldpc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_BR, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q;

    // Opcode decode; irout is stable from ID onwards because ldir only fires in IF.
    logic [5:0] op;
    logic       is_r, is_ialu, is_lw, is_sw, is_br, is_bcc, is_halt, is_legal;

    assign op       = irout[31:26];
    assign is_r     = (op == 6'h00);
    assign is_ialu  = (op >= 6'h01) && (op <= 6'h04);
    assign is_lw    = (op == 6'h08);
    assign is_sw    = (op == 6'h09);
    assign is_br    = (op == 6'h10);
    assign is_bcc   = (op >= 6'h11) && (op <= 6'h13);
    assign is_halt  = (op == 6'h3F);
    assign is_legal = is_r | is_ialu | is_lw | is_sw | is_br | is_bcc | is_halt;

    // State, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (ldpc) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Next-state and per-state control outputs; everything defaults to 0.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        readim    = 1'b0;
        ldir      = 1'b0;
        ldnpc     = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldimm     = 1'b0;
        opcond    = 2'b00;
        alusel1   = 1'b0;
        alusel2   = 1'b0;
        aluen     = 1'b0;
        ldaluout  = 1'b0;
        alufunc   = ALU_ADD;
        seldest   = 1'b0;
        regwrite  = 1'b0;
        writedmem = 1'b0;
        readdmem  = 1'b0;
        ldlmd     = 1'b0;
        selwb     = 1'b0;
        branch    = 1'b0;
        ldpc      = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_IF;
            end
            S_IF: begin
                // ldimm here: the sign-extender reads the raw instruction word.
                readim  = 1'b1;
                ldir    = 1'b1;
                ldnpc   = 1'b1;
                ldimm   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                ldA = 1'b1;
                ldB = 1'b1;
                if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_br) begin
                    state_d = S_BR;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                aluen    = 1'b1;
                ldaluout = 1'b1;
                if (is_r) begin
                    alusel1 = 1'b1;
                    alufunc = irout[3:0];
                end else if (is_ialu) begin
                    alusel1 = 1'b1;
                    alusel2 = 1'b1;
                    case (op[2:0])
                        3'd2:    alufunc = ALU_AND;
                        3'd3:    alufunc = ALU_OR;
                        3'd4:    alufunc = ALU_XOR;
                        default: alufunc = ALU_ADD;
                    endcase
                end else if (is_lw || is_sw) begin
                    alusel1 = 1'b1;
                    alusel2 = 1'b1;
                end else begin
                    // Conditional branch target: NPC + imm.
                    alusel2 = 1'b1;
                end
                state_d = (is_r || is_ialu) ? S_WB : S_MEM;
            end
            S_BR: begin
                branch  = 1'b1;
                ldpc    = 1'b1;
                state_d = S_IF;
            end
            S_MEM: begin
                if (is_lw) begin
                    readdmem = 1'b1;
                    ldlmd    = 1'b1;
                    state_d  = S_WB;
                end else begin
                    ldpc    = 1'b1;
                    state_d = S_IF;
                    if (is_sw) begin
                        writedmem = 1'b1;
                    end else begin
                        // BZ/BNZ/BLTZ = 0x11/0x12/0x13 map directly onto opcond 01/10/11.
                        opcond = op[1:0];
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                ldpc     = 1'b1;
                selwb    = !is_lw;
                seldest  = !is_r;
                state_d  = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for the multicycle control unit.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset, run;
    logic [31:0] irout;
    logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0]  opcond;
    logic        alusel1, alusel2, aluen, ldaluout;
    logic [3:0]  alufunc;
    logic        seldest, regwrite, writedmem, readdmem, ldlmd, selwb;
    logic        branch, ldpc, halted, illegal;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       readim, ldir, ldnpc, ldA, ldB, ldimm;
        logic [1:0] opcond;
        logic       alusel1, alusel2, aluen, ldaluout;
        logic [3:0] alufunc;
        logic       seldest, regwrite, writedmem, readdmem, ldlmd, selwb;
        logic       branch, ldpc, halted, illegal;
    } ctl_t;

    ctl_t got, e;

    control_unit #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .irout(irout),
        .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldA(ldA), .ldB(ldB),
        .ldimm(ldimm), .opcond(opcond), .alusel1(alusel1), .alusel2(alusel2),
        .aluen(aluen), .ldaluout(ldaluout), .alufunc(alufunc),
        .seldest(seldest), .regwrite(regwrite), .writedmem(writedmem),
        .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb), .branch(branch),
        .ldpc(ldpc), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        got = {readim, ldir, ldnpc, ldA, ldB, ldimm, opcond, alusel1, alusel2,
               aluen, ldaluout, alufunc, seldest, regwrite, writedmem, readdmem,
               ldlmd, selwb, branch, ldpc, halted, illegal};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t c_if();
        ctl_t c = '0;
        c.readim = 1'b1; c.ldir = 1'b1; c.ldnpc = 1'b1; c.ldimm = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_id();
        ctl_t c = '0;
        c.ldA = 1'b1; c.ldB = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_ex(input logic s1, input logic s2, input logic [3:0] f);
        ctl_t c = '0;
        c.aluen = 1'b1; c.ldaluout = 1'b1;
        c.alusel1 = s1; c.alusel2 = s2; c.alufunc = f;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic dest_rt, input logic from_alu);
        ctl_t c = '0;
        c.regwrite = 1'b1; c.ldpc = 1'b1;
        c.seldest = dest_rt; c.selwb = from_alu;
        return c;
    endfunction

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        irout = 32'h0;
        repeat (2) tick();
        check("reset_outputs", 64'(got), 64'(ctl_t'('0)));
        check("reset_count", 64'(instr_count), 64'd0);

        // Release reset, pulse run: IF on the next edge.
        reset = 1'b1;
        run   = 1'b1;
        tick();
        run = 1'b0;
        check("if_vector", 64'(got), 64'(c_if()));

        // R-type SUB (funct 0001): IF ID EX WB.
        irout = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01};
        tick(); check("r_id", 64'(got), 64'(c_id()));
        tick(); check("r_ex", 64'(got), 64'(c_ex(1'b1, 1'b0, 4'b0001)));
        tick(); check("r_wb", 64'(got), 64'(c_wb(1'b0, 1'b1)));
        check("r_count_before", 64'(instr_count), 64'd0);
        tick(); check("r_back_if", 64'(got), 64'(c_if()));
        check("r_count_after", 64'(instr_count), 64'd1);

        // LW: IF ID EX MEM WB.
        irout = {6'h08, 5'd1, 5'd2, 16'h0004};
        tick(); check("lw_id", 64'(got), 64'(c_id()));
        tick(); check("lw_ex", 64'(got), 64'(c_ex(1'b1, 1'b1, 4'b0000)));
        e = '0; e.readdmem = 1'b1; e.ldlmd = 1'b1;
        tick(); check("lw_mem", 64'(got), 64'(e));
        tick(); check("lw_wb", 64'(got), 64'(c_wb(1'b1, 1'b0)));
        tick(); check("lw_back_if", 64'(got), 64'(c_if()));
        check("lw_count", 64'(instr_count), 64'd2);

        // XORI: IF ID EX WB, dest rt, ALU result.
        irout = {6'h04, 5'd1, 5'd2, 16'h00FF};
        tick(); check("xori_id", 64'(got), 64'(c_id()));
        tick(); check("xori_ex", 64'(got), 64'(c_ex(1'b1, 1'b1, 4'b0100)));
        tick(); check("xori_wb", 64'(got), 64'(c_wb(1'b1, 1'b1)));
        tick(); check("xori_count", 64'(instr_count), 64'd3);

        // BNZ: IF ID EX MEM, PC load with opcond 10, no regwrite.
        irout = {6'h12, 5'd1, 5'd0, 16'h0010};
        tick(); check("bnz_id", 64'(got), 64'(c_id()));
        tick(); check("bnz_ex", 64'(got), 64'(c_ex(1'b0, 1'b1, 4'b0000)));
        e = '0; e.ldpc = 1'b1; e.opcond = 2'b10;
        tick(); check("bnz_mem", 64'(got), 64'(e));
        tick(); check("bnz_back_if", 64'(got), 64'(c_if()));
        check("bnz_count", 64'(instr_count), 64'd4);

        // BR: IF ID BR (3 cycles).
        irout = {6'h10, 26'h0000010};
        tick(); check("br_id", 64'(got), 64'(c_id()));
        e = '0; e.branch = 1'b1; e.ldpc = 1'b1;
        tick(); check("br_br", 64'(got), 64'(e));
        tick(); check("br_back_if", 64'(got), 64'(c_if()));
        check("br_count", 64'(instr_count), 64'd5);

        // SW, then reset asserted in the middle of MEM.
        irout = {6'h09, 5'd1, 5'd2, 16'h0008};
        tick(); check("sw_id", 64'(got), 64'(c_id()));
        tick(); check("sw_ex", 64'(got), 64'(c_ex(1'b1, 1'b1, 4'b0000)));
        e = '0; e.writedmem = 1'b1; e.ldpc = 1'b1;
        tick(); check("sw_mem", 64'(got), 64'(e));
        reset = 1'b0;
        #1;
        check("sw_reset_writedmem", 64'(writedmem), 64'd0);
        check("sw_reset_outputs", 64'(got), 64'(ctl_t'('0)));
        check("sw_reset_count", 64'(instr_count), 64'd0);
        #2;
        reset = 1'b1;
        tick(); check("idle_hold", 64'(got), 64'(ctl_t'('0)));
        check("idle_count", 64'(instr_count), 64'd0);
        run = 1'b1;
        tick(); check("restart_if", 64'(got), 64'(c_if()));

        // HALT with run held high: stays halted, counter frozen.
        irout = {6'h3F, 26'h0};
        tick(); check("halt_id", 64'(got), 64'(c_id()));
        e = '0; e.halted = 1'b1;
        tick(); check("halt_state", 64'(got), 64'(e));
        repeat (3) tick();
        check("halt_stays", 64'(got), 64'(e));
        check("halt_count", 64'(instr_count), 64'd0);

        // Illegal opcode 0x2A: halted and sticky illegal.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick(); check("ill_if", 64'(got), 64'(c_if()));
        run   = 1'b0;
        irout = {6'h2A, 26'h0};
        tick(); check("ill_id", 64'(got), 64'(c_id()));
        e = '0; e.halted = 1'b1; e.illegal = 1'b1;
        tick(); check("ill_halt", 64'(got), 64'(e));
        irout = {6'h00, 26'h0};
        repeat (2) tick();
        check("ill_sticky", 64'(got), 64'(e));
        check("ill_count", 64'(instr_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
